instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  encode request valid.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 in_opcode  input  4  instruction opcode, placed in word bits [15:12].
REQ-007 in_reg  input  3  register field, used by BranchZ (opcode 4'b0100) only.
REQ-008 in_imm  input  16  full signed immediate value, two's complement.
REQ-009 addr_load  input  1  load the write pointer from addr_in.
REQ-010 addr_in  input  16  new write-pointer value.
REQ-011 mem_we  output  1  instruction-memory write strobe, one cycle per accepted word.
REQ-012 mem_addr  output  16  write address, equal to the current write pointer.
REQ-013 mem_wdata  output  16  encoded instruction word.
REQ-014 err_range  output  1  one-cycle pulse: immediate does not fit its field.
REQ-015 err_count  output  8  saturating count of range errors.

Function
REQ-016 FSM states SHALL be IDLE, ENCODE, WRITE and ERR, with IDLE as the reset state.
REQ-017 in_ready SHALL equal (state==IDLE) and not addr_load.
REQ-018 Handshake: a request SHALL be accepted on the rising edge where in_valid and in_ready are both 1; the edge captures in_opcode, in_reg and in_imm and moves the FSM to ENCODE.
REQ-019 Inputs SHALL be ignored when not accepted; no data is captured outside the handshake.
REQ-020 Range rule for opcode 4'b0100 SHALL be: in_imm[15:8] all equal (value in -256..255).
REQ-021 Range rule for every other opcode SHALL be: in_imm[15:11] all equal (value in -2048..2047).
REQ-022 Encoding for opcode 4'b0100 SHALL be {4'b0100, in_reg, in_imm[8:0]}.
REQ-023 Encoding for every other opcode SHALL be {in_opcode, in_imm[11:0]}; in_reg is ignored.
REQ-024 Round-trip property: sign-extending the immediate field of any in-range encoded word (9-bit field for 0100, 12-bit field otherwise) SHALL reproduce in_imm exactly.
REQ-025 From ENCODE, the FSM SHALL move to WRITE when the range rule holds and to ERR when it fails.
REQ-026 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_wdata holding the encoded word and mem_addr holding the pointer.
REQ-027 On the edge that leaves WRITE, the pointer SHALL increment by 1, wrapping from 16'hFFFF to 16'h0000, and the FSM SHALL return to IDLE.
REQ-028 In ERR, err_range SHALL be 1 for one cycle and mem_we SHALL stay 0.
REQ-029 On the edge that leaves ERR, err_count SHALL increment, holding at 8'hFF once reached; the pointer SHALL be unchanged and the FSM SHALL return to IDLE.
REQ-030 Latency and throughput: for an accept at edge N, mem_we or err_range SHALL be high in the cycle after edge N+1; throughput is one request per 3 cycles.
REQ-031 addr_load SHALL update the pointer only in IDLE; in other states it is ignored.
REQ-032 When addr_load and in_valid are asserted together, addr_load SHALL win and the request SHALL not be accepted that cycle.
REQ-033 mem_wdata SHALL hold its last value outside WRITE; it is meaningful only while mem_we=1.

Reset
REQ-034 While rst=1 at an edge, the FSM SHALL go to IDLE, and mem_we=0, err_range=0, pointer=16'h0000, mem_wdata=16'h0000 and err_count=8'h00.
REQ-035 Reset SHALL take priority over every input in every state; reset asserted during WRITE SHALL suppress any further write and discard the pending word.
REQ-036 in_ready SHALL read 0 during the cycle after a reset edge only if addr_load=1; otherwise it is 1.

Verification
REQ-037 Opcode 4'b0100, in_reg 3'b101, in_imm 16'hFF00 -> one write of 16'h4B00 at address 0, then pointer = 1.
REQ-038 Opcode 4'b0010, in_imm 16'h07FF, followed by opcode 4'b0010, in_imm 16'h0800 -> first a write of 16'h27FF; second gives err_range pulse, no write, err_count=1.
REQ-039 Opcode 4'b0100, in_imm 16'h0100 (256) -> err_range pulse, pointer unchanged; 256 errors in total -> err_count holds at 8'hFF.
REQ-040 addr_load with addr_in 16'hFFFF, then two valid jumps -> writes at 16'hFFFF then 16'h0000.
REQ-041 addr_load and in_valid asserted in the same IDLE cycle -> pointer loaded, request accepted on a later cycle; rst asserted during WRITE -> mem_we=0 next cycle, all outputs at reset values.
REQ-042 Random in-range requests against a reference model -> every word satisfies REQ-024 and pointer = number of writes mod 2^16.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes (opcode, reg, immediate) requests into 16-bit words and writes them to instruction memory.
// Latency: accept at edge N, write strobe or range-error pulse in the cycle after edge N+1.
// Backpressure: in_ready drops while a request is in flight or addr_load is asserted; one request per 3 cycles.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [2:0]  in_reg,
    input  logic [15:0] in_imm,
    input  logic        addr_load,
    input  logic [15:0] addr_in,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        err_range,
    output logic [7:0]  err_count
);

    // BranchZ carries a register field and therefore only a 9-bit immediate.
    localparam logic [3:0] OP_BRZ = 4'b0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t      state;

    // Request fields captured at the handshake; the live inputs are never used after that edge.
    logic [3:0]  op_q;
    logic [2:0]  reg_q;
    logic [15:0] imm_q;

    // Write pointer; mem_addr is a direct view of it.
    logic [15:0] wr_ptr;

    logic        is_brz;
    logic        fits_short;
    logic        fits_long;
    logic        fits;
    logic [15:0] enc_word;

    // Ready only when idle; a pointer load steals the cycle from a request.
    assign in_ready = (state == IDLE) && !addr_load;
    assign mem_addr = wr_ptr;

    // Range check and word assembly from the captured request.
    always_comb begin
        is_brz     = (op_q == OP_BRZ);
        // A value fits an n-bit signed field when all bits above the field's sign bit
        // equal that sign bit, i.e. the top bits are all ones or all zeros.
        fits_short = (&imm_q[15:8])  || !(|imm_q[15:8]);
        fits_long  = (&imm_q[15:11]) || !(|imm_q[15:11]);
        fits       = is_brz ? fits_short : fits_long;
        if (is_brz) begin
            enc_word = {OP_BRZ, reg_q, imm_q[8:0]};
        end else begin
            enc_word = {op_q, imm_q[11:0]};
        end
    end

    // Control FSM with registered write strobe, error pulse, data word, pointer and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 4'h0;
            reg_q     <= 3'h0;
            imm_q     <= 16'h0000;
            wr_ptr    <= 16'h0000;
            mem_we    <= 1'b0;
            mem_wdata <= 16'h0000;
            err_range <= 1'b0;
            err_count <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (addr_load) begin
                        wr_ptr <= addr_in;
                    end else if (in_valid) begin
                        op_q  <= in_opcode;
                        reg_q <= in_reg;
                        imm_q <= in_imm;
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (fits) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= enc_word;
                        state     <= WRITE;
                    end else begin
                        err_range <= 1'b1;
                        state     <= ERR;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    wr_ptr <= wr_ptr + 16'd1;
                    state  <= IDLE;
                end
                ERR: begin
                    err_range <= 1'b0;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    mem_we    <= 1'b0;
                    err_range <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = 4'h0;
    logic [2:0]  in_reg = 3'h0;
    logic [15:0] in_imm = 16'h0000;
    logic        addr_load = 1'b0;
    logic [15:0] addr_in = 16'h0000;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        err_range;
    logic [7:0]  err_count;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_reg    (in_reg),
        .in_imm    (in_imm),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .err_range (err_range),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A request accepted at edge N produces its result in the window after edge N+1,
    // commits pointer/counter at edge N+2, and the next request can be taken at edge N+3.
    int          ecnt = 0;
    int          busy_until = 0;
    int          out_edge = -10;
    int          mv;
    int          m_nwr = 0;
    logic [15:0] m_ptr = 16'h0;
    logic [15:0] m_wdata = 16'h0;
    logic [7:0]  m_cnt = 8'h0;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic        p_ok = 1'b0;
    logic [15:0] p_word = 16'h0;
    logic [15:0] p_imm = 16'h0;
    logic [3:0]  p_op = 4'h0;

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (rst) begin
            m_ptr = 16'h0; m_cnt = 8'h0; m_we = 1'b0; m_err = 1'b0; m_wdata = 16'h0;
            busy_until = ecnt + 1;
            out_edge = -10;
            m_nwr = 0;
        end else begin
            m_we = 1'b0;
            m_err = 1'b0;
            if (ecnt == out_edge) begin
                if (p_ok) begin m_we = 1'b1; m_wdata = p_word; end
                else m_err = 1'b1;
            end
            if (ecnt == out_edge + 1) begin
                if (p_ok) begin m_ptr = m_ptr + 16'd1; m_nwr = m_nwr + 1; end
                else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            if (ecnt >= busy_until) begin
                if (addr_load) begin
                    m_ptr = addr_in;
                end else if (in_valid) begin
                    mv = $signed(in_imm);
                    p_op = in_opcode;
                    p_imm = in_imm;
                    if (in_opcode == 4'b0100) begin
                        p_ok = (mv >= -256) && (mv <= 255);
                        p_word = 16'h4000 + 16'(int'(in_reg) * 512) + 16'(mv & 511);
                    end else begin
                        p_ok = (mv >= -2048) && (mv <= 2047);
                        p_word = 16'(int'(in_opcode) * 4096) + 16'(mv & 4095);
                    end
                    out_edge = ecnt + 1;
                    busy_until = ecnt + 3;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int          nwr_dut = 0;
    int          nerr_dut = 0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] last_addr2 = 16'h0;
    logic [15:0] last_word = 16'h0;
    logic [15:0] se;

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'((ecnt + 1 >= busy_until) && !addr_load));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("err_range", 32'(err_range), 32'(m_err));
            chk("mem_addr", 32'(mem_addr), 32'(m_ptr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("err_count", 32'(err_count), 32'(m_cnt));
            if (mem_we && m_we) begin
                if (p_op == 4'b0100) se = {{7{mem_wdata[8]}}, mem_wdata[8:0]};
                else se = {{4{mem_wdata[11]}}, mem_wdata[11:0]};
                chk("roundtrip", 32'(se), 32'(p_imm));
            end
            if (mem_we) begin
                nwr_dut++;
                last_addr2 = last_addr;
                last_addr = mem_addr;
                last_word = mem_wdata;
            end
            if (err_range) nerr_dut++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] r,
                         input logic [15:0] imm, input logic al, input logic [15:0] ai,
                         input logic rs);
        in_valid = v; in_opcode = op; in_reg = r; in_imm = imm;
        addr_load = al; addr_in = ai; rst = rs;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 3'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] r, input logic [15:0] imm);
        drive(1'b1, op, r, imm, 1'b0, 16'h0, 1'b0);
        idle(3);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 3'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 4'h0, 3'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        idle(1);
    endtask

    logic [3:0]  r_op;
    logic [15:0] r_imm;
    int          w0;

    initial begin
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_errcnt", 32'(err_count), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);

        // BranchZ with negative in-range immediate
        send(4'b0100, 3'b101, 16'hFF00);
        #3;
        chk("brz_word", 32'(last_word), 32'h4B00);
        chk("brz_addr", 32'(last_addr), 32'h0000);
        chk("brz_ptr", 32'(mem_addr), 32'h0001);

        // 12-bit field edge: 2047 fits, 2048 does not
        send(4'b0010, 3'b000, 16'h07FF);
        #3;
        chk("max12_word", 32'(last_word), 32'h27FF);
        w0 = nwr_dut;
        send(4'b0010, 3'b000, 16'h0800);
        #3;
        chk("ovf12_nowrite", 32'(nwr_dut), 32'(w0));
        chk("ovf12_errcnt", 32'(err_count), 32'h01);
        chk("ovf12_pulses", 32'(nerr_dut), 32'd1);

        // 9-bit field edge: 256 does not fit BranchZ
        send(4'b0100, 3'b000, 16'h0100);
        #3;
        chk("ovf9_ptr", 32'(mem_addr), 32'h0002);
        chk("ovf9_errcnt", 32'(err_count), 32'h02);

        // saturate the error counter
        for (int i = 0; i < 256; i++) send(4'b0100, 3'b001, 16'h8000);
        #3;
        chk("errcnt_sat", 32'(err_count), 32'hFF);

        // pointer wrap
        drive(1'b0, 4'h0, 3'h0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
        send(4'b0001, 3'b000, 16'h0001);
        send(4'b0001, 3'b000, 16'h0002);
        #3;
        chk("wrap_addr0", 32'(last_addr2), 32'hFFFF);
        chk("wrap_addr1", 32'(last_addr), 32'h0000);
        chk("wrap_ptr", 32'(mem_addr), 32'h0001);

        // addr_load beats a simultaneous request
        drive(1'b1, 4'b0010, 3'b000, 16'h0005, 1'b1, 16'h1234, 1'b0);
        send(4'b0010, 3'b000, 16'h0005);
        #3;
        chk("ldwin_addr", 32'(last_addr), 32'h1234);
        chk("ldwin_word", 32'(last_word), 32'h2005);
        chk("ldwin_ptr", 32'(mem_addr), 32'h1235);

        // reset while the write strobe is high
        drive(1'b1, 4'b0011, 3'b000, 16'h0010, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 4'h0, 3'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        #3;
        chk("pre_rst_we", 32'(mem_we), 32'h1);
        drive(1'b0, 4'h0, 3'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        #3;
        chk("rstw_we", 32'(mem_we), 32'h0);
        chk("rstw_wdata", 32'(mem_wdata), 32'h0);
        chk("rstw_addr", 32'(mem_addr), 32'h0);
        chk("rstw_errcnt", 32'(err_count), 32'h0);
        idle(3);

        // random in-range traffic, no pointer loads
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r_op = 4'($urandom_range(0, 15));
            if (r_op == 4'b0100) r_imm = 16'($signed($urandom_range(0, 511)) - 256);
            else r_imm = 16'($signed($urandom_range(0, 4095)) - 2048);
            drive(1'($urandom_range(0, 1)), r_op, 3'($urandom_range(0, 7)), r_imm,
                  1'b0, 16'h0, 1'b0);
        end
        idle(4);
        #3;
        chk("ptr_eq_writes", 32'(mem_addr), 32'(m_nwr % 65536));
        chk("no_errors", 32'(err_count), 32'h0);

        // fully random traffic including loads, out-of-range values and resets
        for (int i = 0; i < 2500; i++) begin
            r_op = ($urandom_range(0, 3) == 0) ? 4'b0100 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) r_imm = 16'($urandom);
            else r_imm = 16'($signed($urandom_range(0, 5000)) - 2500);
            drive(1'($urandom_range(0, 1)), r_op, 3'($urandom_range(0, 7)), r_imm,
                  ($urandom_range(0, 15) == 0), 16'($urandom),
                  ($urandom_range(0, 199) == 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
